// File: rtl/roc_aer_scheduler_pkg.sv
// Shared definitions for the ROC encoder / AER scheduler pair: scheduler
// state encoding, default image geometry and event-counter width helper.
package roc_pkg;

    localparam int ROC_IMAGE_SIZE = 256;
    localparam int ROC_INDEX_BITS = $clog2(ROC_IMAGE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        START_ENC,
        WAIT_ENC,
        WAIT_IDX,
        REQ,
        ACK_LOW,
        DONE
    } roc_sched_state_t;

    // Counter must be able to hold the value image_size itself.
    function automatic int roc_cnt_bits(input int image_size);
        return $clog2(image_size + 1);
    endfunction

endpackage

// File: rtl/roc_aer_scheduler_sync_2ff.sv
// 1-bit double-flop synchronizer for asynchronous handshake inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops to resolve metastability on d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/roc_aer_scheduler.sv
// Sequences one image through the ROC encoder and forwards each sorted
// index as an AER address event over a 4-phase REQ/ACK handshake, with an
// early-stop spike budget and an ACK timeout.
module roc_aer_scheduler
    import roc_pkg::*;
#(
    parameter int IMAGE_SIZE  = ROC_IMAGE_SIZE,
    parameter int INDEX_BITS  = $clog2(IMAGE_SIZE),
    parameter int MAX_SPIKES  = IMAGE_SIZE,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_BITS    = roc_cnt_bits(IMAGE_SIZE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  SCHED_RDY,
    output logic                  ENC_NEW_IMAGE,
    input  logic [INDEX_BITS-1:0] NEXT_INDEX,
    input  logic                  FOUND_NEXT_INDEX,
    input  logic                  ENCODER_RDY,
    output logic                  AEROUT_CTRL_BUSY,
    output logic [INDEX_BITS-1:0] AEROUT_ADDR,
    output logic                  AEROUT_REQ,
    input  logic                  AEROUT_ACK,
    output logic [CNT_BITS-1:0]   EVENT_CNT,
    output logic                  INFERENCE_DONE,
    output logic                  FIRST_INFERENCE_DONE,
    output logic                  ACK_ERR
);

    // Timer counts 0..ACK_TIMEOUT-1 inside REQ / ACK_LOW; the last value aborts.
    localparam int TMR_BITS = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(ACK_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(IMAGE_SIZE);
    localparam logic [CNT_BITS-1:0] CNT_STOP  = CNT_BITS'(MAX_SPIKES);

    roc_sched_state_t state_reg, state_next;

    logic [INDEX_BITS-1:0] addr_reg, addr_next;
    logic                  req_reg, req_next;
    logic                  busy_reg, busy_next;
    logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
    logic                  err_reg, err_next;
    logic                  first_done_reg, first_done_next;
    logic [TMR_BITS-1:0]   timer_reg, timer_next;
    logic                  ack_s;

    sync_2ff u_ack_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (AEROUT_ACK),
        .q     (ack_s)
    );

    // State and datapath registers; reset drops REQ/BUSY immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            req_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
            first_done_reg <= 1'b0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            req_reg        <= req_next;
            busy_reg       <= busy_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            first_done_reg <= first_done_next;
            timer_reg      <= timer_next;
        end
    end

    // Next-state and next-register logic for the handshake sequencer.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        req_next        = req_reg;
        busy_next       = busy_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        first_done_next = first_done_reg;
        timer_next      = '0;

        case (state_reg)
            IDLE: begin
                // Count and error survive in IDLE until the host starts again.
                if (START) begin
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = START_ENC;
                end
            end
            START_ENC: begin
                state_next = WAIT_ENC;
            end
            WAIT_ENC: begin
                if (!ENCODER_RDY) begin
                    state_next = WAIT_IDX;
                end
            end
            WAIT_IDX: begin
                busy_next = 1'b0;
                // A found index wins over end-of-sort in the same cycle.
                if (FOUND_NEXT_INDEX) begin
                    addr_next  = NEXT_INDEX;
                    busy_next  = 1'b1;
                    req_next   = 1'b1;
                    state_next = REQ;
                end else if (ENCODER_RDY) begin
                    state_next = DONE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                    state_next = ACK_LOW;
                end else if (timer_reg == TMR_LAST) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ACK_LOW: begin
                if (!ack_s) begin
                    busy_next  = 1'b0;
                    state_next = (cnt_reg == CNT_STOP) ? DONE : WAIT_IDX;
                end else if (timer_reg == TMR_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DONE: begin
                busy_next       = 1'b0;
                first_done_next = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign SCHED_RDY            = (state_reg == IDLE);
    assign ENC_NEW_IMAGE        = (state_reg == START_ENC);
    assign INFERENCE_DONE       = (state_reg == DONE);
    assign AEROUT_CTRL_BUSY     = busy_reg;
    assign AEROUT_ADDR          = addr_reg;
    assign AEROUT_REQ           = req_reg;
    assign EVENT_CNT            = cnt_reg;
    assign FIRST_INFERENCE_DONE = first_done_reg;
    assign ACK_ERR              = err_reg;

endmodule

// File: tb/tb_roc_aer_scheduler.sv
// Bench for roc_aer_scheduler: behavioural ROC encoder and AER receiver,
// a sorted-order model of the image, and directed scenarios.
module tb_roc_aer_scheduler;

    localparam int IMG = 7;
    localparam int IB  = 3;
    localparam int CB  = 3;
    localparam int TMO = 20;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic          start_drv = 1'b0;
    logic          sel = 1'b0;
    logic          start_a, start_b;
    logic [IB-1:0] next_index = '0;
    logic          found = 1'b0;
    logic          enc_rdy = 1'b1;
    logic          ack = 1'b0;

    logic          rdy_a, nimg_a, busy_a, req_a, done_a, fdone_a, err_a;
    logic [IB-1:0] addr_a;
    logic [CB-1:0] cnt_a;
    logic          rdy_b, nimg_b, busy_b, req_b, done_b, fdone_b, err_b;
    logic [IB-1:0] addr_b;
    logic [CB-1:0] cnt_b;

    logic          rdy, nimg, busy, req, done, fdone, err;
    logic [IB-1:0] addr;
    logic [CB-1:0] cnt;

    assign start_a = start_drv & ~sel;
    assign start_b = start_drv & sel;
    assign rdy   = sel ? rdy_b   : rdy_a;
    assign nimg  = sel ? nimg_b  : nimg_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign req   = sel ? req_b   : req_a;
    assign done  = sel ? done_b  : done_a;
    assign fdone = sel ? fdone_b : fdone_a;
    assign err   = sel ? err_b   : err_a;
    assign addr  = sel ? addr_b  : addr_a;
    assign cnt   = sel ? cnt_b   : cnt_a;

    roc_aer_scheduler #(.IMAGE_SIZE(IMG), .INDEX_BITS(IB), .MAX_SPIKES(7),
                        .ACK_TIMEOUT(TMO), .CNT_BITS(CB)) dut_a (
        .CLK(CLK), .RST(RST), .START(start_a), .SCHED_RDY(rdy_a), .ENC_NEW_IMAGE(nimg_a),
        .NEXT_INDEX(next_index), .FOUND_NEXT_INDEX(found), .ENCODER_RDY(enc_rdy),
        .AEROUT_CTRL_BUSY(busy_a), .AEROUT_ADDR(addr_a), .AEROUT_REQ(req_a), .AEROUT_ACK(ack),
        .EVENT_CNT(cnt_a), .INFERENCE_DONE(done_a), .FIRST_INFERENCE_DONE(fdone_a), .ACK_ERR(err_a)
    );

    roc_aer_scheduler #(.IMAGE_SIZE(IMG), .INDEX_BITS(IB), .MAX_SPIKES(3),
                        .ACK_TIMEOUT(TMO), .CNT_BITS(CB)) dut_b (
        .CLK(CLK), .RST(RST), .START(start_b), .SCHED_RDY(rdy_b), .ENC_NEW_IMAGE(nimg_b),
        .NEXT_INDEX(next_index), .FOUND_NEXT_INDEX(found), .ENCODER_RDY(enc_rdy),
        .AEROUT_CTRL_BUSY(busy_b), .AEROUT_ADDR(addr_b), .AEROUT_REQ(req_b), .AEROUT_ACK(ack),
        .EVENT_CNT(cnt_b), .INFERENCE_DONE(done_b), .FIRST_INFERENCE_DONE(fdone_b), .ACK_ERR(err_b)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Model: pixel values and the order the encoder must present them in.
    int image[IMG] = '{10, 200, 30, 255, 0, 90, 90};
    int order[IMG];
    int exp_len = IMG;

    // Highest value first; equal values keep ascending index order.
    task automatic build_order();
        bit taken[IMG];
        int best;
        for (int i = 0; i < IMG; i++) taken[i] = 1'b0;
        for (int k = 0; k < IMG; k++) begin
            best = -1;
            for (int i = 0; i < IMG; i++)
                if (!taken[i] && (best < 0 || image[i] > image[best])) best = i;
            order[k] = best;
            taken[best] = 1'b1;
        end
    endtask

    // Behavioural encoder: restarts on NEW_IMAGE, offers one index per BUSY cycle.
    int enc_pos = 0;
    int enc_cool = 0;
    bit enc_active = 1'b0;
    bit enc_wait = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            found = 1'b0; enc_rdy = 1'b1; enc_active = 1'b0; enc_wait = 1'b0;
        end else if (nimg) begin
            enc_active = 1'b1; enc_pos = 0; enc_cool = 2; enc_wait = 1'b0;
            enc_rdy = 1'b0; found = 1'b0;
        end else if (enc_active) begin
            found = 1'b0;
            if (enc_cool > 0) enc_cool--;
            else if (enc_wait) begin
                if (busy) enc_wait = 1'b0;
            end else if (!busy) begin
                if (enc_pos < IMG) begin
                    found = 1'b1;
                    next_index = IB'(order[enc_pos]);
                    enc_pos++;
                    enc_wait = 1'b1;
                end else begin
                    enc_rdy = 1'b1;
                    enc_active = 1'b0;
                end
            end
        end
    end

    // AER receiver: 0 follows REQ after 3 cycles, 1 stuck low, 2 sticks high once raised.
    int ack_mode = 0;
    int ack_dly = 0;
    always @(negedge CLK) begin
        if (ack_mode == 1) ack = 1'b0;
        else if (ack_mode == 2 && ack) ack = 1'b1;
        else if (req != ack) begin
            ack_dly++;
            if (ack_dly >= 3) begin ack = req; ack_dly = 0; end
        end else ack_dly = 0;
    end

    // Compare process: every REQ cycle must carry the model's next address.
    int  ev_idx = -1;
    int  nimg_total = 0;
    int  done_total = 0;
    int  got_q[$];
    bit  req_prev = 1'b0;
    int  req_hi_len = 0;
    int  last_req_len = 0;
    bit  in_infer = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            if (nimg) begin nimg_total++; ev_idx = -1; end
            if (req && !req_prev) begin
                ev_idx++;
                got_q.push_back(int'(addr));
                req_hi_len = 0;
                chk("event_in_budget", int'(ev_idx < exp_len), 1);
            end
            if (req) begin
                req_hi_len++;
                if (ev_idx >= 0 && ev_idx < exp_len) chk("addr_vs_model", int'(addr), order[ev_idx]);
            end else if (req_prev) last_req_len = req_hi_len;
            if (done) done_total++;
            if (in_infer) chk("rdy_low_in_infer", int'(rdy), 0);
        end
        req_prev = req;
    end

    task automatic start_once();
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin @(negedge CLK); seen = rdy; end
        chk("rdy_before_start", int'(rdy), 1);
        start_drv = 1'b1;
        @(negedge CLK);
        start_drv = 1'b0;
        in_infer = 1'b1;
        chk("new_image_pulse", int'(nimg), 1);
        chk("err_cleared_by_start", int'(err), 0);
        chk("cnt_cleared_by_start", int'(cnt), 0);
    endtask

    task automatic run_inference(input int mid1, input int mid2, input string tag);
        int d0, n0;
        bit seen = 1'b0;
        d0 = done_total;
        n0 = nimg_total;
        start_once();
        for (int c = 1; c < 3000 && !seen; c++) begin
            start_drv = (c == mid1 || c == mid2);
            @(negedge CLK);
            seen = done;
        end
        start_drv = 1'b0;
        in_infer = 1'b0;
        chk("done_within_budget", int'(seen), 1);
        @(negedge CLK);
        chk("rdy_after_done", int'(rdy), 1);
        chk("fdone_set", int'(fdone), 1);
        chk("busy_low_idle", int'(busy), 0);
        repeat (3) @(negedge CLK);
        chk("done_pulses", done_total - d0, 1);
        chk("new_image_count", nimg_total - n0, 1);
        $display("inference %s: events=%0d cnt=%0d ack_err=%0d", tag, got_q.size(), cnt, err);
    endtask

    task automatic check_seq(input int base, input int n, input string tag);
        int lit[IMG] = '{3, 1, 5, 6, 2, 0, 4};
        chk({tag, "_event_count"}, got_q.size() - base, n);
        for (int k = 0; k < n && base + k < got_q.size(); k++)
            chk({tag, "_addr"}, got_q[base + k], lit[k]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pin[IMG] = '{3, 1, 5, 6, 2, 0, 4};
        bit seen;
        build_order();
        for (int k = 0; k < IMG; k++) chk("model_order_pin", order[k], pin[k]);

        // Reset state
        #12;
        chk("rst_sched_rdy", int'(rdy_a), 1);
        chk("rst_req", int'(req_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_fdone", int'(fdone_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_new_image", int'(nimg_a), 0);
        chk("rst_addr", int'(addr_a), 0);
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(negedge CLK);

        // Full image, responsive ACK
        sel = 1'b0; exp_len = 7; base = got_q.size();
        run_inference(-1, -1, "full");
        check_seq(base, 7, "full");
        chk("full_cnt", int'(cnt), 7);
        chk("full_err", int'(err), 0);
        repeat (10) @(negedge CLK);
        chk("cnt_holds_in_idle", int'(cnt), 7);

        // Spike budget of 3, run twice
        sel = 1'b1; exp_len = 3; base = got_q.size();
        run_inference(-1, -1, "budget1");
        check_seq(base, 3, "budget1");
        chk("budget1_cnt", int'(cnt), 3);
        repeat (5) @(negedge CLK);
        chk("budget_cnt_holds", int'(cnt), 3);
        base = got_q.size();
        run_inference(-1, -1, "budget2");
        check_seq(base, 3, "budget2");
        chk("budget2_cnt", int'(cnt), 3);
        repeat (5) @(negedge CLK);

        // ACK never rises: timeout in REQ
        sel = 1'b0; exp_len = 7; ack_mode = 1; base = got_q.size();
        run_inference(-1, -1, "tmo_req");
        check_seq(base, 1, "tmo_req");
        chk("tmo_req_len", last_req_len, TMO);
        chk("tmo_req_err", int'(err), 1);
        chk("tmo_req_cnt", int'(cnt), 0);
        ack_mode = 0;
        repeat (10) @(negedge CLK);

        // ACK stuck high after the first event: timeout in ACK_LOW
        ack_mode = 2; base = got_q.size();
        run_inference(-1, -1, "tmo_ack_low");
        check_seq(base, 1, "tmo_ack_low");
        chk("tmo_ack_low_err", int'(err), 1);
        chk("tmo_ack_low_cnt", int'(cnt), 1);
        ack_mode = 0;
        repeat (10) @(negedge CLK);

        // START pulses mid-inference are ignored
        base = got_q.size();
        run_inference(8, 20, "mid_start");
        check_seq(base, 7, "mid_start");
        chk("mid_start_cnt", int'(cnt), 7);
        chk("mid_start_err", int'(err), 0);

        // Reset while REQ is high on the third event
        base = got_q.size();
        start_once();
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge CLK);
            seen = req && (got_q.size() - base == 3);
        end
        chk("reached_third_req", int'(seen), 1);
        in_infer = 1'b0;
        chk("cnt_before_reset", int'(cnt), 2);
        #2 RST = 1'b0;
        #1;
        chk("arst_req", int'(req), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_rdy", int'(rdy), 1);
        chk("arst_fdone", int'(fdone), 0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        base = got_q.size();
        run_inference(-1, -1, "after_reset");
        check_seq(base, 7, "after_reset");
        chk("after_reset_cnt", int'(cnt), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
